// File: rtl/watchdog_ctrl.sv
// Frame-based watchdog sequencer: counts un-kicked VBL strobes and, on timeout,
// drives a fixed-length registered reset pulse and a sticky expiry flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// ARMED  | counting VBL strobes; KICK clears the count
// FIRING | WD_RESET high; pulse down-counter running to terminal count
// IDLE   | suspended by DISABLE; count held at zero
module watchdog_ctrl #(
    parameter int TIMEOUT_FRAMES = 8,
    parameter int RST_LEN        = 16
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  VBL,
    input  logic                                  KICK,
    input  logic                                  DISABLE,
    input  logic                                  CLR_FLAG,
    output logic                                  WD_RESET,
    output logic                                  nWD_RESET,
    output logic                                  EXPIRED,
    output logic [$clog2(TIMEOUT_FRAMES+1)-1:0]   FRAME_CNT
);

    localparam int FW = $clog2(TIMEOUT_FRAMES + 1);
    localparam int PW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
    localparam logic [FW-1:0] LAST_FRAME = FW'(TIMEOUT_FRAMES - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_LEN - 1);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        FIRING = 2'd1,
        IDLE   = 2'd2
    } wdState_t;

    wdState_t          state, stateNext;
    logic [FW-1:0]     frameCnt, frameNext;
    logic [PW-1:0]     pulseCnt, pulseNext;
    logic              wdReset, wdNext;
    logic              nWdReset;
    logic              expired, expiredNext;
    logic              expireNow;

    always_comb begin
        stateNext   = state;
        frameNext   = frameCnt;
        pulseNext   = pulseCnt;
        wdNext      = wdReset;
        expiredNext = expired;
        expireNow   = 1'b0;

        case (state)
            ARMED: begin
                if (KICK) begin
                    frameNext = '0;
                end else if (VBL) begin
                    if (frameCnt == LAST_FRAME) begin
                        expireNow = 1'b1;
                        stateNext = FIRING;
                        frameNext = '0;
                        pulseNext = PULSE_LOAD;
                        wdNext    = 1'b1;
                    end else begin
                        frameNext = frameCnt + 1'b1;
                    end
                end
                // An expiry this cycle must still fire even if DISABLE is high.
                if (DISABLE && !expireNow) begin
                    stateNext = IDLE;
                    frameNext = '0;
                end
            end
            FIRING: begin
                frameNext = '0;
                if (pulseCnt == '0) begin
                    stateNext = ARMED;
                    wdNext    = 1'b0;
                end else begin
                    pulseNext = pulseCnt - 1'b1;
                end
            end
            IDLE: begin
                frameNext = '0;
                wdNext    = 1'b0;
                if (!DISABLE) begin
                    stateNext = ARMED;
                end
            end
            default: begin
                stateNext = ARMED;
                frameNext = '0;
                pulseNext = '0;
                wdNext    = 1'b0;
            end
        endcase

        if (expireNow) begin
            expiredNext = 1'b1;
        end else if (CLR_FLAG) begin
            expiredNext = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ARMED;
            frameCnt <= '0;
            pulseCnt <= '0;
            wdReset  <= 1'b0;
            nWdReset <= 1'b1;
            expired  <= 1'b0;
        end else begin
            state    <= stateNext;
            frameCnt <= frameNext;
            pulseCnt <= pulseNext;
            wdReset  <= wdNext;
            nWdReset <= ~wdNext;
            expired  <= expiredNext;
        end
    end

    assign WD_RESET  = wdReset;
    assign nWD_RESET = nWdReset;
    assign EXPIRED   = expired;
    assign FRAME_CNT = frameCnt;

endmodule

// File: tb/tb_watchdog_ctrl.sv
// Bench for watchdog_ctrl: directed scenarios plus a randomized run, every cycle
// compared against an integer-level model of the frame/pulse/flag rules.
module tb_watchdog_ctrl;

    localparam int TF = 8;
    localparam int RL = 16;

    logic       CLK = 1'b0;
    logic       RESET, VBL, KICK, DISABLE, CLR_FLAG;
    logic       WD_RESET, nWD_RESET, EXPIRED;
    logic [3:0] FRAME_CNT;

    int totalChecks = 0;
    int badChecks   = 0;

    // reference model: frames seen, reset cycles still to drive, suspended, flag
    int mFrames    = 0;
    int mPulseLeft = 0;
    bit mIdle      = 1'b0;
    bit mExpired   = 1'b0;

    watchdog_ctrl #(.TIMEOUT_FRAMES(TF), .RST_LEN(RL)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .VBL       (VBL),
        .KICK      (KICK),
        .DISABLE   (DISABLE),
        .CLR_FLAG  (CLR_FLAG),
        .WD_RESET  (WD_RESET),
        .nWD_RESET (nWD_RESET),
        .EXPIRED   (EXPIRED),
        .FRAME_CNT (FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input int observed, input int expected);
        totalChecks++;
        if (observed != expected) begin
            badChecks++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep();
        bit expire;
        expire = 1'b0;
        if (RESET) begin
            mFrames = 0; mPulseLeft = 0; mIdle = 1'b0; mExpired = 1'b0;
            return;
        end
        if (mPulseLeft > 0) begin
            mPulseLeft--;
        end else if (mIdle) begin
            if (!DISABLE) mIdle = 1'b0;
        end else begin
            if (KICK) mFrames = 0;
            else if (VBL) begin
                if (mFrames + 1 == TF) begin
                    expire = 1'b1;
                    mFrames = 0;
                    mPulseLeft = RL;
                end else begin
                    mFrames++;
                end
            end
            if (DISABLE && !expire) begin
                mIdle = 1'b1;
                mFrames = 0;
            end
        end
        if (expire) mExpired = 1'b1;
        else if (CLR_FLAG) mExpired = 1'b0;
    endtask

    // One clock: model absorbs the sampled inputs, outputs compared 1ns later, strobes drop.
    task automatic tick();
        @(posedge CLK);
        modelStep();
        #1;
        checkVal("wd_reset",  int'(WD_RESET),  (mPulseLeft > 0) ? 1 : 0);
        checkVal("nwd_reset", int'(nWD_RESET), (mPulseLeft > 0) ? 0 : 1);
        checkVal("expired",   int'(EXPIRED),   int'(mExpired));
        checkVal("frame_cnt", int'(FRAME_CNT), mFrames);
        VBL = 1'b0; KICK = 1'b0; CLR_FLAG = 1'b0; RESET = 1'b0;
    endtask

    task automatic idleTicks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sendVbl(input int gap);
        VBL = 1'b1;
        tick();
        idleTicks(gap);
    endtask

    // Samples WD_RESET now and over the next n cycles, returning how many were high.
    task automatic measurePulse(input int n, output int hi);
        hi = int'(WD_RESET);
        for (int i = 0; i < n; i++) begin
            tick();
            hi += int'(WD_RESET);
        end
    endtask

    initial begin
        int hi;
        int wdSeen;
        RESET = 1'b1; VBL = 1'b0; KICK = 1'b0; DISABLE = 1'b0; CLR_FLAG = 1'b0;
        #2;
        tick();
        RESET = 1'b1;
        tick();
        checkVal("rst_wd",   int'(WD_RESET),  0);
        checkVal("rst_nwd",  int'(nWD_RESET), 1);
        checkVal("rst_exp",  int'(EXPIRED),   0);
        checkVal("rst_fcnt", int'(FRAME_CNT), 0);

        // 1: eight un-kicked frames fire a 16-cycle pulse
        for (int i = 0; i < TF - 1; i++) begin
            VBL = 1'b1;
            tick();
            checkVal("t1_step", int'(FRAME_CNT), i + 1);
            idleTicks(99);
        end
        VBL = 1'b1;
        tick();
        checkVal("t1_rise", int'(WD_RESET), 1);
        measurePulse(30, hi);
        checkVal("t1_len",  hi, RL);
        checkVal("t1_exp",  int'(EXPIRED), 1);
        checkVal("t1_fcnt", int'(FRAME_CNT), 0);

        // 2: kick after seven frames prevents expiry
        wdSeen = 0;
        for (int i = 0; i < TF - 1; i++) begin sendVbl(3); wdSeen += int'(WD_RESET); end
        checkVal("t2_seven", int'(FRAME_CNT), 7);
        KICK = 1'b1;
        tick();
        checkVal("t2_kick", int'(FRAME_CNT), 0);
        for (int i = 0; i < TF - 1; i++) begin sendVbl(3); wdSeen += int'(WD_RESET); end
        checkVal("t2_seven2", int'(FRAME_CNT), 7);
        checkVal("t2_nowd", wdSeen, 0);

        // 3: simultaneous KICK and the expiring VBL
        KICK = 1'b1; VBL = 1'b1;
        tick();
        checkVal("t3_fcnt", int'(FRAME_CNT), 0);
        checkVal("t3_wd",   int'(WD_RESET), 0);
        tick();
        checkVal("t3_wd2",  int'(WD_RESET), 0);

        // 4: reset truncates a pulse in its fifth cycle
        for (int i = 0; i < TF; i++) sendVbl((i == TF - 1) ? 0 : 2);
        checkVal("t4_fire", int'(WD_RESET), 1);
        idleTicks(4);
        RESET = 1'b1;
        tick();
        checkVal("t4_wd",   int'(WD_RESET), 0);
        checkVal("t4_nwd",  int'(nWD_RESET), 1);
        checkVal("t4_exp",  int'(EXPIRED), 0);
        for (int i = 0; i < TF; i++) sendVbl((i == TF - 1) ? 0 : 2);
        measurePulse(25, hi);
        checkVal("t4_len", hi, RL);

        // 5: DISABLE suspends counting
        for (int i = 0; i < 5; i++) sendVbl(2);
        checkVal("t5_five", int'(FRAME_CNT), 5);
        DISABLE = 1'b1;
        tick();
        wdSeen = 0;
        for (int i = 0; i < 20; i++) begin
            sendVbl(1);
            wdSeen += int'(WD_RESET) + int'(FRAME_CNT);
        end
        checkVal("t5_quiet", wdSeen, 0);
        DISABLE = 1'b0;
        tick();
        for (int i = 0; i < TF - 1; i++) sendVbl(2);
        checkVal("t5_pre", int'(WD_RESET), 0);
        VBL = 1'b1;
        tick();
        checkVal("t5_fire", int'(WD_RESET), 1);
        idleTicks(20);

        // 6: set beats clear, lone clear then clears
        checkVal("t6_pre", int'(EXPIRED), 1);
        for (int i = 0; i < TF - 1; i++) sendVbl(1);
        VBL = 1'b1; CLR_FLAG = 1'b1;
        tick();
        checkVal("t6_set", int'(EXPIRED), 1);
        idleTicks(20);
        CLR_FLAG = 1'b1;
        tick();
        checkVal("t6_clr", int'(EXPIRED), 0);

        // randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            VBL      = ($urandom_range(0, 5) == 0);
            KICK     = ($urandom_range(0, 60) == 0);
            CLR_FLAG = ($urandom_range(0, 40) == 0);
            RESET    = ($urandom_range(0, 700) == 0);
            if ($urandom_range(0, 150) == 0) DISABLE = ~DISABLE;
            tick();
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/watchdog_ctrl.md
Name: watchdog_ctrl

Overview:
Frame-based system watchdog sequencer for the NeoGeo core. It replaces the discrete toggle/clear flop chain with one synchronous controller. It counts vertical-blank strobes and is cleared by CPU watchdog-kick writes. On timeout it drives a fixed-length system reset pulse and records a sticky expiry flag. It sits between the LSPC timing (VBL strobe), the 68k address decode (kick strobe) and the global reset tree.

Parameters:
TIMEOUT_FRAMES, 8, number of un-kicked VBL strobes that trigger a reset (must be >= 1)
RST_LEN, 16, WD_RESET pulse length in CLK cycles (must be >= 1)

Ports:
CLK  in  1  system clock; all logic is rising-edge
RESET  in  1  synchronous, active-high reset
VBL  in  1  one-cycle strobe per frame
KICK  in  1  one-cycle strobe on CPU watchdog write
DISABLE  in  1  level; high suspends counting (debug/DIP)
CLR_FLAG  in  1  one-cycle strobe; clears EXPIRED
WD_RESET  out  1  registered reset request to the reset tree, active high
nWD_RESET  out  1  registered complement of WD_RESET
EXPIRED  out  1  sticky flag; set when a timeout fires
FRAME_CNT  out  clog2(TIMEOUT_FRAMES+1)  current un-kicked frame count

Behaviour:
- Reset (RESET=1 at a rising edge): state=ARMED, FRAME_CNT=0, pulse counter=0, WD_RESET=0, nWD_RESET=1, EXPIRED=0. RESET overrides every other input.
- RESET asserted during FIRING: WD_RESET is 0 from the following cycle. The pulse is truncated, not resumed.
- All outputs are registered. No combinational path from inputs to outputs.
- The controller has three states: ARMED, FIRING, IDLE.
- ARMED:
  - KICK=1: FRAME_CNT <= 0. KICK beats a simultaneous VBL.
  - VBL=1, KICK=0, FRAME_CNT < TIMEOUT_FRAMES-1: FRAME_CNT increments by 1.
  - VBL=1, KICK=0, FRAME_CNT == TIMEOUT_FRAMES-1: go to FIRING, FRAME_CNT <= 0, pulse counter <= RST_LEN-1, WD_RESET <= 1, EXPIRED <= 1. WD_RESET is therefore high in the cycle after the expiring VBL.
  - DISABLE=1 with no expiry this cycle: go to IDLE, FRAME_CNT <= 0. Expiry takes priority over DISABLE in the same cycle.
- FIRING:
  - WD_RESET stays 1 for exactly RST_LEN consecutive cycles.
  - The pulse counter decrements each cycle. When it is 0, the next state is ARMED and WD_RESET <= 0.
  - VBL, KICK and DISABLE are ignored; FRAME_CNT holds 0.
  - If DISABLE is still high when the pulse ends, the next cycle goes to IDLE via the ARMED rule.
- IDLE:
  - FRAME_CNT holds 0, WD_RESET=0, VBL and KICK are ignored.
  - DISABLE=0: go to ARMED. Counting starts at the next VBL.
- EXPIRED:
  - Set on entry to FIRING; cleared by CLR_FLAG.
  - Set wins over simultaneous clear.
  - Unaffected by DISABLE.
- nWD_RESET always equals ~WD_RESET, including during reset.
- FRAME_CNT never exceeds TIMEOUT_FRAMES-1. There is no wrap-around; expiry replaces the wrap.
- Back-to-back expiries: after the pulse ends, a fresh TIMEOUT_FRAMES un-kicked VBLs are needed before the next pulse.
- Target size: about 150 RTL lines: state register, two counters, flag, output registers.

Test Plan:
1. Defaults, release RESET, issue 8 VBL strobes 100 cycles apart with no KICK. FRAME_CNT steps 0..7. WD_RESET rises 1 cycle after the 8th VBL and stays high for exactly 16 cycles. EXPIRED=1. FRAME_CNT=0.
2. 7 VBLs, then KICK, then 7 more VBLs. No WD_RESET. FRAME_CNT reads 7, 0, then 7.
3. At FRAME_CNT=7, assert KICK and VBL in the same cycle. FRAME_CNT becomes 0 and WD_RESET stays 0.
4. Assert RESET at cycle 5 of a firing pulse. WD_RESET=0 the next cycle, EXPIRED=0, state ARMED. A further 8 VBLs produce a full 16-cycle pulse.
5. Assert DISABLE at FRAME_CNT=5, send 20 VBLs, drop DISABLE, send 8 VBLs. No reset while disabled. FRAME_CNT reads 0 throughout. A pulse fires after the 8th VBL following re-enable.
6. With EXPIRED=1, pulse CLR_FLAG in the same cycle as a new expiry. EXPIRED stays 1. A later lone CLR_FLAG gives EXPIRED=0 the next cycle.
